// File: rtl/mixed_radix_down_timer_pkg.sv
// Shared constants for the mixed-radix countdown timer: default geometry, m:ss radices and
// the behaviour of the count when it reaches all-zero.
package mixed_radix_down_timer_pkg;

  localparam int unsigned DefaultNumDigits = 3;
  localparam int unsigned DefaultDigitW    = 4;

  // Radix of digit i sits in byte i: LSD 10, tens-of-seconds 6, minutes 10.
  localparam logic [23:0] DefaultRadix = 24'h0A060A;

  localparam bit ModeSaturate = 1'b0;
  localparam bit ModeWrap     = 1'b1;

endpackage

// File: rtl/mixed_radix_down_timer_digit.sv
// One countdown digit of configurable radix with clamped load and a borrow chain.
module mixed_radix_down_timer_digit #(
  parameter int unsigned DigitW = 4,
  parameter int unsigned Radix  = 10
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic [DigitW-1:0] load_value,
  input  logic              count,
  input  logic              borrow_in,
  output logic [DigitW-1:0] value,
  output logic              zero,
  output logic              borrow_out
);

  localparam logic [DigitW:0]   RadixW = Radix[DigitW:0];
  localparam logic [DigitW-1:0] MaxVal = RadixW[DigitW-1:0] - 1'b1;

  logic [DigitW-1:0] value_q, value_d;
  logic              dec;

  assign dec        = count & borrow_in;
  assign zero       = (value_q == '0);
  assign borrow_out = borrow_in & zero;
  assign value      = value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      // Out-of-range load values saturate to the largest legal digit.
      value_d = ({1'b0, load_value} >= RadixW) ? MaxVal : load_value;
    end else if (dec) begin
      value_d = zero ? MaxVal : value_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/mixed_radix_down_timer.sv
// Chained mixed-radix down-counter with load clamp, saturate-or-wrap at zero and a done pulse.
module mixed_radix_down_timer
  import mixed_radix_down_timer_pkg::*;
#(
  parameter int unsigned               NUM_DIGITS = DefaultNumDigits,
  parameter int unsigned               DIGIT_W    = DefaultDigitW,
  parameter logic [NUM_DIGITS*8-1:0]   RADIX      = DefaultRadix,
  parameter bit                        WRAP_MODE  = ModeSaturate
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          loadn,
  input  logic                          enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data_in,
  output logic [NUM_DIGITS*DIGIT_W-1:0] data_out,
  output logic                          zero,
  output logic                          tc,
  output logic                          done
);

  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS:0]   borrow;
  logic                  load;
  logic                  count;
  logic                  last_one;
  logic                  done_q, done_d;

  assign load      = ~loadn;
  assign zero      = &digit_zero;
  assign tc        = zero & enable;
  assign borrow[0] = 1'b1;

  // In saturate mode the all-zero state simply ignores enable.
  assign count = enable & ~load & (WRAP_MODE | ~zero);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
    mixed_radix_down_timer_digit #(
      .DigitW(DIGIT_W),
      .Radix (int'(RADIX[g*8 +: 8]))
    ) u_digit (
      .clock     (clock),
      .clear     (clear),
      .load      (load),
      .load_value(data_in[g*DIGIT_W +: DIGIT_W]),
      .count     (count),
      .borrow_in (borrow[g]),
      .value     (data_out[g*DIGIT_W +: DIGIT_W]),
      .zero      (digit_zero[g]),
      .borrow_out(borrow[g+1])
    );
  end

  // A decrement from "...001" is the only count step that lands on all-zero.
  assign last_one = (data_out[DIGIT_W-1:0] == DIGIT_W'(1)) &
                    (&(digit_zero | NUM_DIGITS'(1)));

  always_comb begin
    done_d = count & ~zero & last_one;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_mixed_radix_down_timer.sv
// Directed table-driven bench for the m:ss countdown timer in saturate and wrap modes.
module tb_mixed_radix_down_timer;

  logic        clock;
  logic        clear;
  logic        loadn, enable;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        zero, tc, done;

  logic        w_loadn, w_enable;
  logic [11:0] w_data_in;
  logic [11:0] w_data_out;
  logic        w_zero, w_tc, w_done;

  int total = 0;
  int bad   = 0;

  mixed_radix_down_timer dut (
    .clock   (clock),
    .clear   (clear),
    .loadn   (loadn),
    .enable  (enable),
    .data_in (data_in),
    .data_out(data_out),
    .zero    (zero),
    .tc      (tc),
    .done    (done)
  );

  mixed_radix_down_timer #(
    .WRAP_MODE(1'b1)
  ) dut_w (
    .clock   (clock),
    .clear   (clear),
    .loadn   (w_loadn),
    .enable  (w_enable),
    .data_in (w_data_in),
    .data_out(w_data_out),
    .zero    (w_zero),
    .tc      (w_tc),
    .done    (w_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        loadn;
    logic        enable;
    logic [11:0] din;
    logic        exp_tc;
    logic [11:0] exp_q;
    logic        exp_zero;
    logic        exp_done;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clock);
    loadn   = v.loadn;
    enable  = v.enable;
    data_in = v.din;
    #1;
    check($sformatf("v%0d_tc", idx), {11'b0, tc}, {11'b0, v.exp_tc});
    @(posedge clock);
    #1;
    check($sformatf("v%0d_q", idx), data_out, v.exp_q);
    check($sformatf("v%0d_zero", idx), {11'b0, zero}, {11'b0, v.exp_zero});
    check($sformatf("v%0d_done", idx), {11'b0, done}, {11'b0, v.exp_done});
  endtask

  initial begin
    //         loadn enable din     tc    q       zero  done
    vecs[0]  = '{1'b0, 1'b0, 12'h100, 1'b0, 12'h100, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 12'h000, 1'b0, 12'h059, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 12'h001, 1'b0, 12'h001, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 12'h0F9, 1'b0, 12'h059, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 12'hFFF, 1'b0, 12'h959, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 12'h123, 1'b0, 12'h123, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 12'h000, 1'b0, 12'h122, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 12'h010, 1'b0, 12'h010, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 12'h000, 1'b0, 12'h009, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0};

    clear     = 1'b0;
    loadn     = 1'b1;
    enable    = 1'b0;
    data_in   = '0;
    w_loadn   = 1'b1;
    w_enable  = 1'b0;
    w_data_in = '0;

    // Reset state, with tc tracking enable while clear is held.
    #12;
    check("rst_q", data_out, 12'h000);
    check("rst_zero", {11'b0, zero}, 12'h001);
    check("rst_done", {11'b0, done}, 12'h000);
    check("rst_tc_off", {11'b0, tc}, 12'h000);
    enable = 1'b1;
    #1;
    check("rst_tc_on", {11'b0, tc}, 12'h001);
    @(posedge clock);
    #1;
    check("rst_hold", data_out, 12'h000);
    @(negedge clock);
    enable = 1'b0;
    clear  = 1'b1;

    for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

    // Wrap mode: all-zero with enable rolls every digit to radix-1, no done.
    @(negedge clock);
    w_loadn   = 1'b0;
    w_data_in = 12'h000;
    @(posedge clock);
    #1;
    check("wrap_load", w_data_out, 12'h000);
    @(negedge clock);
    w_loadn  = 1'b1;
    w_enable = 1'b1;
    #1;
    check("wrap_tc", {11'b0, w_tc}, 12'h001);
    @(posedge clock);
    #1;
    check("wrap_q", w_data_out, 12'h959);
    check("wrap_done", {11'b0, w_done}, 12'h000);
    check("wrap_zero", {11'b0, w_zero}, 12'h000);
    @(negedge clock);
    w_enable = 1'b0;

    // Asynchronous clear mid-count.
    loadn   = 1'b0;
    data_in = 12'h030;
    @(posedge clock);
    #1;
    check("clr_load", data_out, 12'h030);
    @(negedge clock);
    loadn  = 1'b1;
    enable = 1'b1;
    @(posedge clock);
    #1;
    check("clr_cnt", data_out, 12'h029);
    #2;
    clear = 1'b0;
    #1;
    check("clr_async_q", data_out, 12'h000);
    check("clr_async_zero", {11'b0, zero}, 12'h001);
    check("clr_async_tc", {11'b0, tc}, 12'h001);
    @(posedge clock);
    #1;
    check("clr_held", data_out, 12'h000);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    check("clr_rel_q", data_out, 12'h000);
    check("clr_rel_done", {11'b0, done}, 12'h000);
    @(negedge clock);
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
